// File: rtl/regfile_sb_if.sv
// Decode/writeback-side bus of the integer register file with busy-bit scoreboard.
// The master drives reads, issue and writeback; the slave is the register file.
interface regfile_sb_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2
);
  localparam int NREGS = 2**ADDR_W;

  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_hazard;

  logic                     wb_en;
  logic [ADDR_W-1:0]        wb_addr;
  logic [DATA_W-1:0]        wb_data;

  logic                     iss_en;
  logic [ADDR_W-1:0]        iss_addr;
  logic                     flush;

  logic [NREGS-1:0]         busy_vec;
  logic [ADDR_W:0]          busy_cnt;
  logic [DATA_W-1:0]        dbg_data;

  modport master (
    output rd_addr, wb_en, wb_addr, wb_data, iss_en, iss_addr, flush,
    input  rd_data, rd_hazard, busy_vec, busy_cnt, dbg_data
  );

  modport slave (
    input  rd_addr, wb_en, wb_addr, wb_data, iss_en, iss_addr, flush,
    output rd_data, rd_hazard, busy_vec, busy_cnt, dbg_data
  );
endinterface

// File: rtl/regfile_sb.sv
// Parametrised integer register file with asynchronous read ports, optional
// writeback bypass and a busy-bit scoreboard feeding the stall logic.
module regfile_sb #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int NUM_RD  = 2,
  parameter int BYPASS  = 1,
  parameter int DBG_REG = 10
) (
  input logic         clk,
  input logic         rst,
  regfile_sb_if.slave bus
);
  localparam int NREGS = 2**ADDR_W;
  localparam bit USE_BYP = (BYPASS != 0);
  localparam logic [ADDR_W-1:0] DBG_IDX = ADDR_W'(DBG_REG);

  generate
    if (NUM_RD < 1 || NUM_RD > 4) begin : g_bad_num_rd
      $error("regfile_sb: NUM_RD must be in 1..4");
    end
    if (DBG_REG < 0 || DBG_REG >= NREGS) begin : g_bad_dbg_reg
      $error("regfile_sb: DBG_REG must be below NREGS");
    end
  endgenerate

  logic [DATA_W-1:0] regs [NREGS];
  logic [NREGS-1:0]  busy;
  logic [NREGS-1:0]  busy_nxt;
  logic [ADDR_W:0]   cnt;
  logic [ADDR_W:0]   cnt_nxt;
  logic              wb_live;
  logic              iss_live;
  logic              cnt_inc;
  logic              cnt_dec;

  assign wb_live  = bus.wb_en  && (bus.wb_addr  != '0);
  assign iss_live = bus.iss_en && (bus.iss_addr != '0);

  // Register 0 is held at zero by never accepting a write to it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < NREGS; r++) begin
        regs[r] <= '0;
      end
    end else if (wb_live) begin
      regs[bus.wb_addr] <= bus.wb_data;
    end
  end

  // Flush wins over everything; a same-cycle issue wins over writeback.
  always_comb begin
    busy_nxt = busy;
    if (bus.flush) begin
      busy_nxt = '0;
    end else begin
      if (wb_live && !(iss_live && bus.iss_addr == bus.wb_addr)) begin
        busy_nxt[bus.wb_addr] = 1'b0;
      end
      if (iss_live) begin
        busy_nxt[bus.iss_addr] = 1'b1;
      end
    end
    busy_nxt[0] = 1'b0;
  end

  // Incremental count: only a real 0->1 or 1->0 transition moves it.
  always_comb begin
    cnt_inc = iss_live && !busy[bus.iss_addr];
    cnt_dec = wb_live && busy[bus.wb_addr] &&
              !(iss_live && bus.iss_addr == bus.wb_addr);
    if (bus.flush) begin
      cnt_nxt = '0;
    end else begin
      cnt_nxt = cnt + (ADDR_W+1)'(cnt_inc) - (ADDR_W+1)'(cnt_dec);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy <= '0;
      cnt  <= '0;
    end else begin
      busy <= busy_nxt;
      cnt  <= cnt_nxt;
    end
  end

  assign bus.busy_vec = busy;
  assign bus.busy_cnt = cnt;
  assign bus.dbg_data = regs[DBG_IDX];

  // Forwarding is suppressed in reset so every read port returns zero there.
  generate
    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
      logic [ADDR_W-1:0] addr;
      logic              fwd;

      assign addr = bus.rd_addr[i*ADDR_W +: ADDR_W];
      assign fwd  = USE_BYP && rst && bus.wb_en && (bus.wb_addr == addr);

      assign bus.rd_data[i*DATA_W +: DATA_W] =
        (addr == '0) ? '0 :
        fwd          ? bus.wb_data :
                       regs[addr];

      assign bus.rd_hazard[i] = (addr != '0) && busy[addr] && !fwd;
    end
  endgenerate
endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench: one bypassing and one non-bypassing register file driven
// in lockstep, compared against a behavioural model through an expectation queue.
module tb_regfile_sb;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 2;
  localparam int NREGS = 2**AW;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  regfile_sb_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) bus1 ();
  regfile_sb_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) bus0 ();

  regfile_sb #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .BYPASS(1), .DBG_REG(10))
    dut1 (.clk(clk), .rst(rst), .bus(bus1));
  regfile_sb #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .BYPASS(0), .DBG_REG(10))
    dut0 (.clk(clk), .rst(rst), .bus(bus0));

  typedef struct {
    string            tag;
    logic [NR*DW-1:0] data [2];
    logic [NR-1:0]    haz [2];
    logic [NREGS-1:0] busy_vec;
    logic [AW:0]      busy_cnt;
    logic [DW-1:0]    dbg;
  } exp_t;

  exp_t sbq[$];

  logic [DW-1:0] mreg [NREGS];
  bit            mbusy [NREGS];

  logic [AW-1:0] cur_a [NR];
  logic          cur_we;
  logic [AW-1:0] cur_wa;
  logic [DW-1:0] cur_wd;
  logic          cur_ie;
  logic [AW-1:0] cur_ia;
  logic          cur_fl;

  int nChecks = 0;
  int nErrors = 0;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nChecks++;
    if (got !== exp) begin
      nErrors++;
      $display("[TB] FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic modelReset();
    for (int r = 0; r < NREGS; r++) begin
      mreg[r]  = '0;
      mbusy[r] = 1'b0;
    end
  endtask

  task automatic driveInputs();
    bus1.rd_addr = {cur_a[1], cur_a[0]};
    bus0.rd_addr = {cur_a[1], cur_a[0]};
    bus1.wb_en = cur_we;   bus0.wb_en = cur_we;
    bus1.wb_addr = cur_wa; bus0.wb_addr = cur_wa;
    bus1.wb_data = cur_wd; bus0.wb_data = cur_wd;
    bus1.iss_en = cur_ie;  bus0.iss_en = cur_ie;
    bus1.iss_addr = cur_ia; bus0.iss_addr = cur_ia;
    bus1.flush = cur_fl;   bus0.flush = cur_fl;
  endtask

  function automatic exp_t buildExpect(input string tag);
    exp_t e;
    int   cnt = 0;
    e.tag = tag;
    for (int bp = 0; bp < 2; bp++) begin
      for (int i = 0; i < NR; i++) begin
        logic fwd;
        fwd = (bp == 1) && rst && cur_we && (cur_wa == cur_a[i]);
        if (cur_a[i] == '0)  e.data[bp][i*DW +: DW] = '0;
        else if (fwd)        e.data[bp][i*DW +: DW] = cur_wd;
        else                 e.data[bp][i*DW +: DW] = mreg[cur_a[i]];
        e.haz[bp][i] = (cur_a[i] != '0) && mbusy[cur_a[i]] && !fwd;
      end
    end
    for (int r = 0; r < NREGS; r++) begin
      e.busy_vec[r] = mbusy[r];
      if (mbusy[r]) cnt++;
    end
    e.busy_cnt = (AW+1)'(cnt);
    e.dbg = mreg[10];
    return e;
  endfunction

  task automatic compareFront();
    exp_t e;
    e = sbq.pop_front();
    checkOutput({e.tag, ".rd_data.byp"},   64'(bus1.rd_data),   64'(e.data[1]));
    checkOutput({e.tag, ".rd_data.nobyp"}, 64'(bus0.rd_data),   64'(e.data[0]));
    checkOutput({e.tag, ".hazard.byp"},    64'(bus1.rd_hazard), 64'(e.haz[1]));
    checkOutput({e.tag, ".hazard.nobyp"},  64'(bus0.rd_hazard), 64'(e.haz[0]));
    checkOutput({e.tag, ".busy_vec.byp"},  64'(bus1.busy_vec),  64'(e.busy_vec));
    checkOutput({e.tag, ".busy_vec.nobyp"},64'(bus0.busy_vec),  64'(e.busy_vec));
    checkOutput({e.tag, ".busy_cnt.byp"},  64'(bus1.busy_cnt),  64'(e.busy_cnt));
    checkOutput({e.tag, ".busy_cnt.nobyp"},64'(bus0.busy_cnt),  64'(e.busy_cnt));
    checkOutput({e.tag, ".dbg.byp"},       64'(bus1.dbg_data),  64'(e.dbg));
    checkOutput({e.tag, ".dbg.nobyp"},     64'(bus0.dbg_data),  64'(e.dbg));
  endtask

  // Model of one rising edge, written per register in priority order.
  task automatic modelEdge();
    if (!rst) return;
    for (int r = 1; r < NREGS; r++) begin
      if (cur_fl)                             mbusy[r] = 1'b0;
      else if (cur_ie && cur_ia == AW'(r))    mbusy[r] = 1'b1;
      else if (cur_we && cur_wa == AW'(r))    mbusy[r] = 1'b0;
    end
    if (cur_we && cur_wa != '0) mreg[cur_wa] = cur_wd;
  endtask

  // Called just after a rising edge; returns just after the following one.
  task automatic applyStimulus(input string tag,
                               input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                               input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                               input logic ie, input logic [AW-1:0] ia, input logic fl);
    cur_a[0] = a0; cur_a[1] = a1;
    cur_we = we; cur_wa = wa; cur_wd = wd;
    cur_ie = ie; cur_ia = ia; cur_fl = fl;
    driveInputs();
    #2;
    sbq.push_back(buildExpect(tag));
    compareFront();
    @(posedge clk);
    modelEdge();
    #1;
  endtask

  initial begin
    rst = 1'b0;
    modelReset();
    cur_a[0] = '0; cur_a[1] = '0;
    cur_we = 1'b1; cur_wa = '0; cur_wd = 32'hDEADBEEF;
    cur_ie = 1'b0; cur_ia = '0; cur_fl = 1'b0;
    driveInputs();
    repeat (2) @(posedge clk);
    #1;

    applyStimulus("rst.hold", 5'd0, 5'd0, 1'b1, 5'd0, 32'hDEADBEEF, 1'b0, 5'd0, 1'b0);
    rst = 1'b1;
    applyStimulus("x0.write", 5'd0, 5'd0, 1'b1, 5'd0, 32'hDEADBEEF, 1'b0, 5'd0, 1'b0);
    applyStimulus("x0.read",  5'd0, 5'd0, 1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 1'b0);
    checkOutput("x0.rd_data", 64'(bus1.rd_data), 64'h0);

    applyStimulus("wr.x5",  5'd5, 5'd10, 1'b1, 5'd5,  32'h12345678, 1'b0, 5'd0, 1'b0);
    applyStimulus("wr.x10", 5'd5, 5'd10, 1'b1, 5'd10, 32'hCAFEF00D, 1'b0, 5'd0, 1'b0);
    applyStimulus("rd.x5x10", 5'd5, 5'd10, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0);
    checkOutput("basic.port0", 64'(bus1.rd_data[31:0]),  64'h12345678);
    checkOutput("basic.port1", 64'(bus1.rd_data[63:32]), 64'hCAFEF00D);
    checkOutput("basic.dbg",   64'(bus1.dbg_data),       64'hCAFEF00D);

    applyStimulus("iss.x7", 5'd7, 5'd0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 1'b0);
    for (int k = 0; k < 3; k++) begin
      applyStimulus("busy.x7", 5'd7, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0);
    end
    checkOutput("sb.hazard_busy", 64'(bus1.rd_hazard[0]), 64'h1);
    checkOutput("sb.cnt_busy",    64'(bus1.busy_cnt),     64'h1);
    cur_a[0] = 5'd7; cur_a[1] = 5'd0; cur_we = 1'b1; cur_wa = 5'd7; cur_wd = 32'h55;
    cur_ie = 1'b0; cur_ia = '0; cur_fl = 1'b0;
    driveInputs();
    #2;
    checkOutput("wbcyc.hazard.byp",   64'(bus1.rd_hazard[0]),  64'h0);
    checkOutput("wbcyc.data.byp",     64'(bus1.rd_data[31:0]), 64'h55);
    checkOutput("wbcyc.hazard.nobyp", 64'(bus0.rd_hazard[0]),  64'h1);
    checkOutput("wbcyc.data.nobyp",   64'(bus0.rd_data[31:0]), 64'h0);
    sbq.push_back(buildExpect("wb.x7"));
    compareFront();
    @(posedge clk);
    modelEdge();
    #1;
    applyStimulus("after.x7", 5'd7, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0);
    checkOutput("after.hazard.nobyp", 64'(bus0.rd_hazard[0]),  64'h0);
    checkOutput("after.data.nobyp",   64'(bus0.rd_data[31:0]), 64'h55);
    checkOutput("after.cnt",          64'(bus1.busy_cnt),      64'h0);

    applyStimulus("iss.x3",  5'd3, 5'd0, 1'b0, 5'd0, 32'h0,   1'b1, 5'd3, 1'b0);
    applyStimulus("isswb.x3", 5'd3, 5'd0, 1'b1, 5'd3, 32'h333, 1'b1, 5'd3, 1'b0);
    applyStimulus("rd.x3",   5'd3, 5'd0, 1'b0, 5'd0, 32'h0,   1'b0, 5'd0, 1'b0);
    checkOutput("isswb.data",  64'(bus0.rd_data[31:0]), 64'h333);
    checkOutput("isswb.busy3", 64'(bus1.busy_vec[3]),   64'h1);
    checkOutput("isswb.cnt",   64'(bus1.busy_cnt),      64'h1);
    applyStimulus("clr.x3",  5'd3, 5'd0, 1'b1, 5'd3, 32'h333, 1'b0, 5'd0, 1'b0);

    applyStimulus("iss.x1", 5'd1, 5'd2, 1'b0, 5'd0, 32'h0, 1'b1, 5'd1, 1'b0);
    applyStimulus("iss.x2", 5'd1, 5'd2, 1'b0, 5'd0, 32'h0, 1'b1, 5'd2, 1'b0);
    applyStimulus("iss.x4", 5'd1, 5'd2, 1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 1'b0);
    checkOutput("flush.cnt_before", 64'(bus1.busy_cnt), 64'h3);
    applyStimulus("flush",  5'd5, 5'd6, 1'b0, 5'd0, 32'h0, 1'b1, 5'd6, 1'b1);
    applyStimulus("postflush", 5'd5, 5'd3, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0);
    checkOutput("flush.busy_vec", 64'(bus1.busy_vec), 64'h0);
    checkOutput("flush.cnt",      64'(bus1.busy_cnt), 64'h0);
    checkOutput("flush.data_x5",  64'(bus1.rd_data[31:0]), 64'h12345678);

    for (int k = 0; k < 60; k++) begin
      applyStimulus("rand",
                    AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)),
                    1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), DW'($urandom),
                    1'($urandom_range(0, 2) != 0), AW'($urandom_range(0, 7)),
                    1'($urandom_range(0, 15) == 0));
    end

    applyStimulus("ld.x9",  5'd9, 5'd10, 1'b1, 5'd9, 32'h99999999, 1'b0, 5'd0, 1'b0);
    applyStimulus("iss.x9", 5'd9, 5'd10, 1'b0, 5'd0, 32'h0,        1'b1, 5'd9, 1'b0);
    cur_a[0] = 5'd9; cur_a[1] = 5'd10; cur_we = 1'b1; cur_wa = 5'd9; cur_wd = 32'hAAAA5555;
    cur_ie = 1'b0; cur_ia = '0; cur_fl = 1'b0;
    driveInputs();
    #2;
    rst = 1'b0;
    modelReset();
    #1;
    checkOutput("arst.rd_data.byp",   64'(bus1.rd_data),   64'h0);
    checkOutput("arst.rd_data.nobyp", 64'(bus0.rd_data),   64'h0);
    checkOutput("arst.hazard",        64'(bus1.rd_hazard), 64'h0);
    checkOutput("arst.busy_vec",      64'(bus1.busy_vec),  64'h0);
    checkOutput("arst.busy_cnt",      64'(bus1.busy_cnt),  64'h0);
    checkOutput("arst.dbg",           64'(bus1.dbg_data),  64'h0);
    @(posedge clk);
    #1;
    applyStimulus("arst.hold", 5'd9, 5'd10, 1'b1, 5'd9, 32'hAAAA5555, 1'b1, 5'd9, 1'b0);
    rst = 1'b1;
    applyStimulus("arst.after", 5'd9, 5'd10, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0);
    checkOutput("arst.wb_ignored", 64'(bus1.rd_data[31:0]), 64'h0);

    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end
endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised successor to the core's integer register file.
- Configurable data width, address width and number of asynchronous read ports, plus optional write-to-read bypass.
- Integrated scoreboard of busy bits: decode sets a destination busy at issue, writeback clears it.
- Sits between decode (read and issue side) and writeback. Per-read-port hazard flags drive the pipeline stall logic.

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, register index width; NREGS = 2**ADDR_W.
- NUM_RD, 2, number of read ports (1..4).
- BYPASS, 1, 1 = same-cycle writeback is forwarded to read ports; 0 = reads see the array only.
- DBG_REG, 10, index of the register mirrored on dbg_data (a0 by default).

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- rd_addr  in  NUM_RD*ADDR_W  packed read addresses; port i = bits [i*ADDR_W +: ADDR_W].
- rd_data  out  NUM_RD*DATA_W  packed read data, combinational.
- rd_hazard  out  NUM_RD  1 = port i's source register has a pending write not satisfied this cycle.
- wb_en  in  1  writeback enable.
- wb_addr  in  ADDR_W  writeback register index.
- wb_data  in  DATA_W  writeback data.
- iss_en  in  1  issue: mark iss_addr as pending.
- iss_addr  in  ADDR_W  destination of the issuing instruction.
- flush  in  1  clear all busy bits (pipeline flush); register data is untouched.
- busy_vec  out  NREGS  registered busy bits; bit 0 is always 0.
- busy_cnt  out  ADDR_W+1  registered count of set busy bits.
- dbg_data  out  DATA_W  array contents of DBG_REG (no bypass).

Behaviour:
- Reset (rst=0, asynchronous):
  - all registers = 0, busy_vec = 0, busy_cnt = 0.
  - rd_data then reads 0; rd_hazard = 0; dbg_data = 0.
  - Reset asserted mid-operation discards any same-edge write or issue.
- Register 0:
  - reads 0 on every port and is never written.
  - wb_addr=0 and iss_addr=0 are ignored for data and busy.
  - rd_hazard is never set for address 0.
- Write:
  - at the rising edge with wb_en=1 and wb_addr!=0, regs[wb_addr] <= wb_data.
  - Writes are accepted whether or not the target is busy.
- Read, per port i, combinational, zero latency:
  - if rd_addr_i = 0, rd_data_i = 0.
  - else if BYPASS=1, wb_en=1 and wb_addr = rd_addr_i, rd_data_i = wb_data.
  - else rd_data_i = regs[rd_addr_i].
- Hazard, per port i:
  - rd_hazard_i = (rd_addr_i != 0) & busy[rd_addr_i] & ~(BYPASS & wb_en & wb_addr == rd_addr_i).
  - With BYPASS=0, the hazard persists through the writeback cycle and clears the cycle after.
- Scoreboard next-state, per register r != 0, in priority order:
  1. flush=1 -> busy[r] <= 0 (issue in the same cycle is discarded).
  2. iss_en & iss_addr == r -> busy[r] <= 1 (issue beats a same-cycle writeback to the same register).
  3. wb_en & wb_addr == r -> busy[r] <= 0.
  4. otherwise hold.
- busy_cnt:
  - updated incrementally each cycle by +1, -1 or 0 for issue/clear combinations.
  - flush loads 0.
  - Must always equal popcount(busy_vec); no wrap is possible since the maximum is NREGS-1.
- Issue to an already-busy register keeps it busy (count unchanged). No other errors are flagged.
- Synthesis/elaboration: assertion rejects NUM_RD outside 1..4 and DBG_REG >= NREGS.

Test Plan:
- Reset and x0:
  - Stimulus: hold rst=0, then release; wb_en=1, wb_addr=0, wb_data=32'hDEADBEEF; read addr 0 on all ports.
  - Required: rd_data = 0, busy_vec = 0, busy_cnt = 0, rd_hazard = 0.
- Basic write and read:
  - Stimulus: write x5=32'h12345678, then x10=32'hCAFEF00D.
  - Required: next cycle, port0 addr 5 reads 32'h12345678, port1 addr 10 reads 32'hCAFEF00D; dbg_data = 32'hCAFEF00D.
- Scoreboard:
  - Stimulus: issue x7; port0 reads x7 for 3 cycles; then writeback x7=32'h55.
  - Required: rd_hazard[0] = 1 while busy; busy_cnt = 1.
  - Writeback cycle, BYPASS=1: rd_hazard[0] = 0 and rd_data = 32'h55; busy_cnt = 0 after the edge.
  - Repeat with BYPASS=0: hazard still 1 in the writeback cycle, reads the old value, and clears the next cycle.
- Simultaneous issue and writeback on the same register:
  - Stimulus: x3 busy; same cycle iss_en=1 and wb_en=1 to x3.
  - Required: x3 gets the wb_data; busy[3] stays 1; busy_cnt unchanged.
- Flush:
  - Stimulus: issue x1, x2, x4 (busy_cnt = 3); then flush=1 together with iss_en to x6.
  - Required: busy_vec = 0, busy_cnt = 0; register data unchanged.
- Asynchronous reset mid-stream:
  - Stimulus: with x9 busy and data loaded, drop rst between clock edges.
  - Required: all outputs 0 immediately, before the next edge; a wb_en at the following edge is ignored while rst=0.
